// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode encoding and slice sizing.
package pipelined_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Bits per pipeline stage; 0 flags an illegal WIDTH/STAGES combination.
    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        if (stages == 0 || stages > width || (width % stages) != 0) begin
            return 0;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module adder_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             ci_i,
    output logic [SLICE-1:0] s_o,
    output logic             co_o,
    output logic             c_msb_o
);
    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = ci_i;
        for (int unsigned i = 0; i < SLICE; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign co_o    = c[SLICE];
    assign c_msb_o = c[SLICE-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined N-bit add/subtract: one operand slice per stage, carry registered between stages,
// global-stall valid/ready handshake on both sides.
module pipelined_adder_n
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned SLICE_RAW = slice_w(WIDTH, STAGES);
    localparam int unsigned SLICE     = (SLICE_RAW == 0) ? 1 : SLICE_RAW;
    localparam int unsigned LAST      = STAGES - 1;

    if (SLICE_RAW == 0) begin : g_param_check
        $error("pipelined_adder_n: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0 (WIDTH=%0d STAGES=%0d)",
               WIDTH, STAGES);
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Each stage carries the full operands forward (skew) and the growing low sum (deskew).
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [STAGES-1:0] c_in, v_in;

    logic [SLICE-1:0]  slice_s [STAGES];
    logic [STAGES-1:0] slice_co, slice_cm;
    logic              unused_bits;

    // Stage inputs: stage 0 sees prepared operands, later stages see the previous stage register.
    always_comb begin
        adv     = !vld_q[LAST] || out_ready;
        b_eff   = (sub == MODE_ADD) ? b : ~b;
        c0      = (sub == MODE_SUB) ? 1'b1 : cin;
        a_in[0] = a;
        b_in[0] = b_eff;
        s_in[0] = '0;
        c_in[0] = c0;
        v_in[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
            v_in[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a_i    (a_in[k][k*SLICE +: SLICE]),
            .b_i    (b_in[k][k*SLICE +: SLICE]),
            .ci_i   (c_in[k]),
            .s_o    (slice_s[k]),
            .co_o   (slice_co[k]),
            .c_msb_o(slice_cm[k])
        );
    end

    // Global stall: every stage shifts together or holds; data only loads behind a valid beat.
    always_comb begin
        vld_d = vld_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
        end
        if (adv) begin
            vld_d = v_in;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (v_in[k]) begin
                    a_d[k]                   = a_in[k];
                    b_d[k]                   = b_in[k];
                    s_d[k]                   = s_in[k];
                    s_d[k][k*SLICE +: SLICE] = slice_s[k];
                    c_d[k]                   = slice_co[k];
                end
            end
            if (v_in[LAST]) begin
                ovf_d = slice_co[LAST] ^ slice_cm[LAST];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    // Last-stage operand copies and non-MSB slice carries have no consumer.
    assign unused_bits = ^{slice_cm, a_q[LAST], b_q[LAST]};

    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Self-checking bench: three configurations (16/4, 16/1, 32/8) checked against an arithmetic model.
module tb_pipelined_adder_n;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid  [NDUT];
    logic        out_ready [NDUT];
    logic        cin_r     [NDUT];
    logic        sub_r     [NDUT];
    logic [31:0] a_r       [NDUT];
    logic [31:0] b_r       [NDUT];
    logic        in_ready  [NDUT];
    logic        out_valid [NDUT];
    logic        cout_w    [NDUT];
    logic        ovf_w     [NDUT];
    logic [15:0] sum0, sum1;
    logic [31:0] sum2;

    pipelined_adder_n #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_r[0][15:0]), .b(b_r[0][15:0]), .cin(cin_r[0]), .sub(sub_r[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum0), .cout(cout_w[0]), .ovf(ovf_w[0]));

    pipelined_adder_n #(.WIDTH(16), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_r[1][15:0]), .b(b_r[1][15:0]), .cin(cin_r[1]), .sub(sub_r[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1), .cout(cout_w[1]), .ovf(ovf_w[1]));

    pipelined_adder_n #(.WIDTH(32), .STAGES(8)) u_dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_r[2]), .b(b_r[2]), .cin(cin_r[2]), .sub(sub_r[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum2), .cout(cout_w[2]), .ovf(ovf_w[2]));

    int          ncmp = 0;
    int          nfail = 0;
    logic [33:0] sbq [NDUT][$];
    logic [31:0] outs0 [$];
    logic        stall_prev [NDUT];
    logic [33:0] held [NDUT];
    logic        acc_flag [NDUT];
    int          acc_cnt [NDUT];
    int          out_cnt [NDUT];

    function automatic int unsigned wid(int i);
        return (i == 2) ? 32 : 16;
    endfunction

    function automatic logic [31:0] sum_of(int i);
        case (i)
            0:       return 32'(sum0);
            1:       return 32'(sum1);
            default: return sum2;
        endcase
    endfunction

    // Reference: plain unsigned/signed integer arithmetic on w-bit operands.
    function automatic logic [33:0] model(int unsigned w, logic [31:0] a, logic [31:0] b, logic ci, logic sb);
        longint m, half, ua, ub, sa, sbv, ures, sres;
        logic   co, ov;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sbv  = (ub >= half) ? ub - (m + 1) : ub;
        if (sb) begin
            ures = ua - ub;
            sres = sa - sbv;
            co   = (ua >= ub);
        end else begin
            ures = ua + ub + longint'(ci);
            sres = sa + sbv + longint'(ci);
            co   = (ures > m);
        end
        ov = (sres >= half) || (sres < -half);
        return {ov, co, 32'(ures & m)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: settle, score handshakes for every DUT, then advance to the next falling edge.
    task automatic tick();
        logic [33:0] got, exp;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            got = {ovf_w[i], cout_w[i], sum_of(i)};
            check("in_ready_rule", 64'(in_ready[i]), 64'(!out_valid[i] || out_ready[i]));
            if (stall_prev[i]) begin
                check("hold_valid", 64'(out_valid[i]), 64'd1);
                check("hold_data", 64'(got), 64'(held[i]));
            end
            if (out_valid[i] && out_ready[i]) begin
                out_cnt[i]++;
                if (i == 0) outs0.push_back(sum_of(0));
                check("beat_expected", 64'(sbq[i].size() != 0), 64'd1);
                if (sbq[i].size() != 0) begin
                    exp = sbq[i].pop_front();
                    check("result", 64'(got), 64'(exp));
                end
            end
            acc_flag[i] = in_valid[i] && in_ready[i];
            if (acc_flag[i]) begin
                acc_cnt[i]++;
                sbq[i].push_back(model(wid(i), a_r[i], b_r[i], cin_r[i], sub_r[i]));
            end
            stall_prev[i] = out_valid[i] && !out_ready[i];
            held[i]       = got;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_one(int i, logic [31:0] a, logic [31:0] b, logic ci, logic sb,
                           logic [31:0] es, logic ec, logic eo, int elat);
        int lat;
        in_valid[i] = 1'b1; a_r[i] = a; b_r[i] = b; cin_r[i] = ci; sub_r[i] = sb; out_ready[i] = 1'b1;
        tick();
        check("dir_accept", 64'(acc_flag[i]), 64'd1);
        in_valid[i] = 1'b0;
        lat = 1;
        while (!out_valid[i] && lat < 40) begin
            tick();
            lat++;
        end
        check("dir_latency", 64'(lat), 64'(elat));
        check("dir_sum", 64'(sum_of(i)), 64'(es));
        check("dir_cout", 64'(cout_w[i]), 64'(ec));
        check("dir_ovf", 64'(ovf_w[i]), 64'(eo));
        tick();
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_8000;
            4:       return 32'h0000_7FFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int bi, cc, saw_block, cyc;
        bit busy;
        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1; cin_r[i] = 1'b0; sub_r[i] = 1'b0;
            a_r[i] = '0; b_r[i] = '0; stall_prev[i] = 1'b0; held[i] = '0;
            acc_flag[i] = 1'b0; acc_cnt[i] = 0; out_cnt[i] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_out_valid", 64'(out_valid[i]), 64'd0);
            check("rst_sum", 64'(sum_of(i)), 64'd0);
            check("rst_cout", 64'(cout_w[i]), 64'd0);
            check("rst_ovf", 64'(ovf_w[i]), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready[0]), 64'd1);
        @(negedge clk);

        // Directed vectors with their stated results and latencies.
        run_one(0, 32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0, 4);
        run_one(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0, 4);
        run_one(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 4);
        run_one(0, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 4);
        run_one(0, 32'h8000, 32'h0001, 1'b1, 1'b1, 32'h7FFF, 1'b1, 1'b1, 4);
        run_one(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 4);
        run_one(1, 32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0, 1);
        run_one(1, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1);
        run_one(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8);
        run_one(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 8);

        // Back-pressure: 8 beats a=b=i with a 5-cycle downstream stall mid-stream.
        outs0.delete();
        bi = 0; cc = 0; saw_block = 0;
        while ((bi < 8 || out_valid[0] || sbq[0].size() != 0) && cc < 60) begin
            in_valid[0]  = (bi < 8);
            a_r[0]       = 32'(bi);
            b_r[0]       = 32'(bi);
            cin_r[0]     = 1'b0;
            sub_r[0]     = 1'b0;
            out_ready[0] = !(cc >= 4 && cc < 9);
            #1;
            if (!in_ready[0]) saw_block = 1;
            tick();
            if (acc_flag[0]) bi++;
            cc++;
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        check("bp_in_ready_dropped", 64'(saw_block), 64'd1);
        check("bp_count", 64'(outs0.size()), 64'd8);
        for (int j = 0; j < 8 && j < outs0.size(); j++) begin
            check("bp_value", 64'(outs0[j]), 64'(2 * j));
        end

        // Reset with three beats in flight flushes them.
        for (int j = 0; j < 3; j++) begin
            in_valid[0] = 1'b1; a_r[0] = 32'h0100 + 32'(j); b_r[0] = 32'h0011; sub_r[0] = 1'b0;
            tick();
        end
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        check("midrst_sum", 64'(sum0), 64'd0);
        for (int i = 0; i < NDUT; i++) begin
            sbq[i].delete();
            stall_prev[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            check("no_stale_beat", 64'(out_valid[0]), 64'd0);
        end

        // Random valid/ready traffic, 1000 beats per configuration.
        for (int i = 0; i < NDUT; i++) acc_cnt[i] = 0;
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < 20000) begin
            for (int i = 0; i < NDUT; i++) begin
                in_valid[i]  = (acc_cnt[i] < 1000) && ($urandom_range(0, 3) != 0);
                out_ready[i] = ($urandom_range(0, 3) != 0);
                a_r[i]       = rnd_op();
                b_r[i]       = rnd_op();
                cin_r[i]     = 1'($urandom_range(0, 1));
                sub_r[i]     = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            busy = 1'b0;
            for (int i = 0; i < NDUT; i++) begin
                if (acc_cnt[i] < 1000 || sbq[i].size() != 0) busy = 1'b1;
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            check("rand_accepted", 64'(acc_cnt[i]), 64'd1000);
            check("rand_drained", 64'(sbq[i].size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
